// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type, parity constants and parity helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} uart_state_t;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD = 1'b1;
  localparam int MAX_DATA_WIDTH = 64;
  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] word, input logic ptype);
    return ptype == PARITY_EVEN ? ^word : (ptype == PARITY_ODD) ^ (^word);
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts oversample ticks and flags the last tick of each serial bit
module uart_bit_timer #(
  parameter int OverSampling = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);
  localparam int CW = $clog2(OverSampling);
  logic [CW-1:0] cnt;
  assign bit_end = enable && cnt == CW'(OverSampling - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= clear || bit_end ? '0 : enable ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises a parallel word LSB-first as start, data, optional parity and stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int Data_Width = 8,
  parameter int OverSampling = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_start,
  input  logic [Data_Width-1:0] data_in,
  input  logic                  parity_en,
  input  logic                  parity_type,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);
  localparam int IW = $clog2(Data_Width + 1);
  uart_state_t state, state_d;
  logic [Data_Width-1:0] shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic par_en_q, par_en_d, par_q, par_d, tx_d, bit_end;
  uart_bit_timer #(.OverSampling(OverSampling)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE),
    .enable(state != IDLE && state != DONE),
    .bit_end(bit_end)
  );
  always_comb begin
    state_d = state;
    shift_d = shift_q;
    idx_d = idx_q;
    par_en_d = par_en_q;
    par_d = par_q;
    unique case (state)
      IDLE:
        if (tx_start) begin
          state_d = START;
          shift_d = data_in;
          par_en_d = parity_en;
          par_d = parity_bit(MAX_DATA_WIDTH'(data_in), parity_type);
        end
      START:
        if (bit_end) begin
          state_d = DATA;
          idx_d = '0;
        end
      DATA:
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(Data_Width - 1)) state_d = par_en_q ? PARITY : STOP;
        end
      PARITY: state_d = bit_end ? STOP : state;
      STOP: state_d = bit_end ? DONE : state;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      shift_q <= '0;
      idx_q <= '0;
      par_en_q <= 1'b0;
      par_q <= 1'b0;
      tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      par_en_q <= par_en_d;
      par_q <= par_d;
      tx <= tx_d;
      tx_busy <= state_d != IDLE;
      tx_done <= state_d == DONE;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter, the send-side counterpart of the team's UART receiver.
- Accepts a parallel word via a start/busy handshake and serialises it LSB-first onto `tx`. Frame: 1 start bit, Data_Width data bits, optional parity bit, 1 stop bit.
- Each bit is held for OverSampling `clk` cycles, so it runs off the same oversampled clock as the receiver.
- Sits between the host/register interface and the serial pin.

Parameters:
- Data_Width, 8: number of data bits per frame.
- OverSampling, 16: `clk` cycles per serial bit. Must be ≥ 2.

Ports:
- clk  input  1  system clock, one tick per oversample period.
- reset  input  1  asynchronous, active-low reset.
- tx_start  input  1  request to send `data_in`; sampled only in IDLE.
- data_in  input  Data_Width  word to transmit; captured on acceptance.
- parity_en  input  1  1 = insert a parity bit; captured on acceptance.
- parity_type  input  1  0 = even, 1 = odd; captured on acceptance.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (async, active-low): state = IDLE, `tx` = 1, `tx_busy` = 0, `tx_done` = 0, bit counter = 0, bit index = 0, shift register = 0. Reset asserted mid-frame aborts the frame; `tx` returns high immediately. No partial frame resumes after reset release.
- All outputs are registered or decoded only from registered state; `tx` must be glitch-free.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: `tx` = 1, `tx_busy` = 0.
  - If `tx_start` = 1 at a rising edge: latch `data_in` into the shift register, latch `parity_en`/`parity_type`, clear the counter, go to START.
- START: `tx` = 0 for OverSampling cycles. When the counter reaches OverSampling-1, clear it, set bit index = 0, go to DATA.
- DATA: `tx` = shift_reg[0]. At counter = OverSampling-1, shift right by 1 and increment bit index.
  - After bit index Data_Width-1 completes: go to PARITY if latched parity_en = 1, else STOP.
- PARITY: `tx` = parity bit for OverSampling cycles, then go to STOP.
  - Even: parity bit = XOR-reduce of the latched word.
  - Odd: parity bit = inverse of that.
  - Computed from the word latched at acceptance, not from the shifting register.
- STOP: `tx` = 1 for OverSampling cycles, then go to DONE.
- DONE: exactly one cycle. `tx` = 1, `tx_done` = 1, `tx_busy` = 1. Then go to IDLE.
- `tx_busy` = (state != IDLE); it rises the cycle after acceptance.
- `tx_start` outside IDLE is ignored and not queued. It includes DONE.
- Back-to-back: `tx_start` held high continuously is accepted in the IDLE cycle after DONE. That gives 1 idle-high cycle plus the DONE cycle between frames.
- Changes to `data_in`, `parity_en` or `parity_type` after acceptance have no effect on the current frame.
- Frame length from acceptance edge to `tx_done` pulse: (2 + Data_Width + parity_en) × OverSampling cycles, plus 1.
- Counter width: $clog2(OverSampling). Bit index width: $clog2(Data_Width+1). Both wrap only by explicit clear, never by overflow.

Decomposition:
- Shared package `uart_pkg`:
  - `uart_state_t` enum (IDLE, START, DATA, PARITY, STOP, DONE), reusable by the receiver.
  - Parity-type constants PARITY_EVEN = 0, PARITY_ODD = 1.
  - A function computing the parity bit from a word and a parity type.
- Sub-module `uart_bit_timer`, parameterised by OverSampling:
  - Inputs: clear, enable.
  - Output: `bit_end` pulse at count OverSampling-1.
  - Used by the transmitter here and reusable in the receiver.
- The FSM, shift register and output register stay in `uart_tx`.

Test Plan (Data_Width = 8, OverSampling = 16):
- `data_in` = 0x9C, parity_en = 0, one-cycle `tx_start`:
  - `tx` bits, 16 cycles each: 0 | 0,0,1,1,1,0,0,1 | 1.
  - `tx_done` pulses 161 cycles after acceptance; `tx_busy` is high throughout.
- 0x9C, parity_en = 1, parity_type = 0: parity slot = 0 (four ones); frame = 176 cycles + DONE.
- 0x9C, parity_en = 1, parity_type = 1: parity slot = 1. Also 0x01 even gives parity = 1.
- Pulse `tx_start` with 0x55 at cycle 40 of a 0xA3 frame: no effect; the 0xA3 frame completes unchanged and `tx` returns to idle high.
- Assert reset at cycle 70 of a frame:
  - `tx` = 1, `tx_busy` = 0 immediately.
  - After release, a new 0x3C frame transmits correctly.
- `tx_start` held high with 0xFF then 0x00:
  - Second start bit begins exactly 2 cycles after the first stop bit ends.
  - Both frames are bit-exact and `tx_done` pulses twice.
